alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
//
// PURPOSE
//   Initiator side of the combinational ALU interface.
//   Accepts packed ALU commands on a valid/ready port and drives registered operands and
//   controls into the ALU.
//   Samples Out/Invalid/Odd_parity one cycle later, checks parity and returns a response
//   on a valid/ready port.
//   Keeps saturating operation and error counters for debug.
//
// PARAMETERS
//   BITS     4   operand width; ALU result width is BITS+1
//   TAG_W    2   width of command tag echoed in the response
//   COUNT_W  16  width of op_count / err_count
//
// PORTS
//   clk             in   1          clock, all logic on rising edge
//   rst_n           in   1          synchronous active-low reset
//   cmd_valid       in   1          command present
//   cmd_ready       out  1          sequencer can accept a command
//   cmd_a           in   BITS       operand A
//   cmd_b           in   BITS       operand B
//   cmd_opcode      in   3          ALU opcode
//   cmd_cin         in   1          carry in
//   cmd_red_a       in   1          reduction-on-A request
//   cmd_red_b       in   1          reduction-on-B request
//   cmd_byp_a       in   1          bypass-A request
//   cmd_byp_b       in   1          bypass-B request
//   cmd_tag         in   TAG_W      command tag
//   alu_a           out  BITS       ALU operand A
//   alu_b           out  BITS       ALU operand B
//   alu_opcode      out  3          ALU opcode
//   alu_cin         out  1          ALU carry in
//   alu_red_a       out  1          ALU reduction-A control
//   alu_red_b       out  1          ALU reduction-B control
//   alu_byp_a       out  1          ALU bypass-A control
//   alu_byp_b       out  1          ALU bypass-B control
//   alu_out         in   BITS+1     ALU result
//   alu_odd_parity  in   1          ALU parity bit (= ~^alu_out when healthy)
//   alu_invalid     in   1          ALU invalid flag
//   rsp_valid       out  1          response present
//   rsp_ready       in   1          downstream accepts response
//   rsp_result      out  BITS+1     captured ALU result
//   rsp_invalid     out  1          captured ALU invalid flag
//   rsp_parity_err  out  1          alu_odd_parity != ~^alu_out at capture
//   rsp_tag         out  TAG_W      tag of the command
//   cnt_clr         in   1          synchronous clear of both counters
//   op_count        out  COUNT_W    completed responses, saturating
//   err_count       out  COUNT_W    responses with rsp_invalid|rsp_parity_err, saturating
//
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - state=IDLE; all alu_* = 0; all rsp_* = 0; counters = 0
//     - cmd_ready = 0 while rst_n=0; any in-flight command is dropped, no response issued
//   FSM IDLE -> DRIVE -> RESP -> IDLE:
//     - IDLE:  cmd_ready=1. At an edge with cmd_valid=1, register all cmd_* fields onto
//       alu_*/tag and go to DRIVE.
//     - DRIVE: cmd_ready=0, alu_* held stable. At the next edge:
//       * capture alu_out -> rsp_result, alu_invalid -> rsp_invalid
//       * capture (alu_odd_parity ^ ~^alu_out) -> rsp_parity_err
//       * set rsp_valid=1 and go to RESP
//     - RESP:  cmd_ready=0; rsp_* and alu_* held stable while rsp_ready=0. At an edge with
//       rsp_ready=1: clear rsp_valid, update counters, go to IDLE.
//   Timing:
//     - Latency: command accepted at edge N -> rsp_valid high after edge N+1.
//     - Throughput: at most 1 command per 3 cycles; cmd and rsp handshakes never coincide.
//   Operands and results:
//     - Opcodes 110/111 and reduction/bypass combinations pass through unmodified.
//     - The ALU decides invalidity; the sequencer only transports it.
//     - rsp_result is the full BITS+1 value, no truncation or extension.
//   Counters:
//     - op_count += 1 on each response handshake.
//     - err_count += 1 on each response handshake with rsp_invalid|rsp_parity_err.
//     - Both saturate at all-ones; no wrap.
//     - cnt_clr has priority over a same-cycle increment (result 0).
//   rst_n low mid-RESP or mid-DRIVE -> IDLE next edge, rsp_valid=0.
//
// TESTING (BITS=4, bench ALU model attached to alu_* ports)
//   1. Reset: rst_n=0 for 2 cycles with cmd_valid=1 -> cmd_ready=0, rsp_valid=0,
//      op_count=err_count=0, alu_a=0.
//   2. ADD: A=9, B=8, cin=1, op=010, tag=2 accepted at edge N -> rsp_valid after N+1,
//      rsp_result=5'h12, rsp_invalid=0, rsp_parity_err=0, rsp_tag=2, op_count=1.
//   3. Backpressure: rsp_ready=0 for 5 cycles, cmd_valid=1 with a new command ->
//      rsp_result stable, cmd_ready=0; rsp_ready=1 -> IDLE, new command accepted next edge.
//   4. Invalid: op=110 -> rsp_invalid=1, err_count=1; op=010 with red_a=1 ->
//      rsp_invalid=1, err_count=2.
//   5. Parity fault: model drives alu_odd_parity inverted on A=3, B=1, op=000 ->
//      rsp_parity_err=1, err_count increments.
//   6. COUNT_W=2: 5 commands -> op_count=3 (saturated); cnt_clr on a completing
//      handshake -> op_count=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: registers valid/ready ALU commands onto a combinational ALU and returns parity-checked responses with saturating counters
module alu_cmd_sequencer #(
  parameter int BITS    = 4,
  parameter int TAG_W   = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [BITS-1:0]    cmd_a,
  input  logic [BITS-1:0]    cmd_b,
  input  logic [2:0]         cmd_opcode,
  input  logic               cmd_cin,
  input  logic               cmd_red_a,
  input  logic               cmd_red_b,
  input  logic               cmd_byp_a,
  input  logic               cmd_byp_b,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic [BITS-1:0]    alu_a,
  output logic [BITS-1:0]    alu_b,
  output logic [2:0]         alu_opcode,
  output logic               alu_cin,
  output logic               alu_red_a,
  output logic               alu_red_b,
  output logic               alu_byp_a,
  output logic               alu_byp_b,
  input  logic [BITS:0]      alu_out,
  input  logic               alu_odd_parity,
  input  logic               alu_invalid,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BITS:0]      rsp_result,
  output logic               rsp_invalid,
  output logic               rsp_parity_err,
  output logic [TAG_W-1:0]   rsp_tag,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] op_count,
  output logic [COUNT_W-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  state_t state;
  logic [TAG_W-1:0] tag_q;
  logic rsp_hs;
  assign cmd_ready = rst_n && state == IDLE;
  assign rsp_hs = state == RESP && rsp_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_opcode     <= '0;
      alu_cin        <= 1'b0;
      alu_red_a      <= 1'b0;
      alu_red_b      <= 1'b0;
      alu_byp_a      <= 1'b0;
      alu_byp_b      <= 1'b0;
      tag_q          <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_invalid    <= 1'b0;
      rsp_parity_err <= 1'b0;
      rsp_tag        <= '0;
      op_count       <= '0;
      err_count      <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          alu_a      <= cmd_a;
          alu_b      <= cmd_b;
          alu_opcode <= cmd_opcode;
          alu_cin    <= cmd_cin;
          alu_red_a  <= cmd_red_a;
          alu_red_b  <= cmd_red_b;
          alu_byp_a  <= cmd_byp_a;
          alu_byp_b  <= cmd_byp_b;
          tag_q      <= cmd_tag;
          state      <= DRIVE;
        end
        DRIVE: begin
          rsp_result     <= alu_out;
          rsp_invalid    <= alu_invalid;
          rsp_parity_err <= alu_odd_parity ^ ~^alu_out;
          rsp_tag        <= tag_q;
          rsp_valid      <= 1'b1;
          state          <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      op_count  <= cnt_clr ? '0 : rsp_hs && !(&op_count) ? op_count + COUNT_W'(1) : op_count;
      err_count <= cnt_clr ? '0 : rsp_hs && (rsp_invalid || rsp_parity_err) && !(&err_count) ? err_count + COUNT_W'(1) : err_count;
    end
  end
endmodule
